// File: rtl/mem_copy_engine_pkg.sv
// Shared types and constants for the RAM block copy/fill engine.
// The width defaults match the 8K x 32 program/data RAM.
package mem_copy_engine_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WT   = 3'd2,
    WR   = 3'd3,
    FILL = 3'd4,
    FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Command and RAM-pin bundle of the copy engine. The engine uses the master
// modport; the CPU polling logic and the RAM together sit on the slave side.
interface mem_copy_engine_if
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  // Handshake: start is a one-cycle strobe that is accepted only while the
  // engine is idle (busy=0, done=0). Command fields are sampled on that same
  // edge. busy stays high while the command runs, and done pulses for exactly
  // one cycle at the end. A start seen at any other time is dropped.
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] fill_val;
  logic              busy;
  logic              done;
  logic              mem_w_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    output busy, done, mem_w_en, mem_addr, mem_wdata
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    input  busy, done, mem_w_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_copy_engine.sv
// RAM block copy (3 cycles/word) and fill (1 cycle/word) master.
// All outputs decode from registered state only.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_copy_engine_if.master   bus,
  output state_t              state_dbg
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] data_q, fill_q;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0)              state_d = FIN;
          else if (bus.mode == MODE_FILL) state_d = FILL;
          else                            state_d = RD;
        end
      end
      RD:      state_d = WT;
      WT:      state_d = WR;
      WR:      state_d = (remaining == (ADDR_W+1)'(1)) ? FIN : RD;
      FILL:    state_d = (remaining == (ADDR_W+1)'(1)) ? FIN : FILL;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointers wrap naturally at ADDR_W bits; remaining is one bit wider so
  // that a full-RAM count of 2^ADDR_W fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_q    <= '0;
      fill_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            src_ptr   <= bus.src_addr;
            dst_ptr   <= bus.dst_addr;
            remaining <= bus.len;
            fill_q    <= bus.fill_val;
          end
        end
        WT: data_q <= bus.mem_rdata;
        WR: begin
          src_ptr   <= src_ptr + ADDR_W'(1);
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
        end
        FILL: begin
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_w_en  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      RD, WT: begin
        bus.busy     = 1'b1;
        bus.mem_addr = src_ptr;
      end
      WR: begin
        bus.busy      = 1'b1;
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = dst_ptr;
        bus.mem_wdata = data_q;
      end
      FILL: begin
        bus.busy      = 1'b1;
        bus.mem_w_en  = 1'b1;
        bus.mem_addr  = dst_ptr;
        bus.mem_wdata = fill_q;
      end
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
